// File: rtl/decimator.sv
`default_nettype none
// ============================================================================
// Module      : decimator
// Description : Integer downsampler. Keeps the last sample of every group of
//               DECIMATION_FACTOR accepted inputs and presents it on a
//               single-entry valid/ready output register. No filtering.
// Revision    : 1.0 - initial release
// ============================================================================
module decimator #(
    parameter int WORD_LENGTH_BITS  = 12,
    parameter int DECIMATION_FACTOR = 5
) (
    input  logic                        clk,
    input  logic                        rst,        // asynchronous, active-low
    input  logic [WORD_LENGTH_BITS-1:0] in,
    input  logic                        in_valid,
    output logic [WORD_LENGTH_BITS-1:0] out,
    output logic                        out_valid,
    input  logic                        out_ready
);

    // Phase counter needs at least one bit even when every input is kept.
    localparam int PHASE_W = (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIMATION_FACTOR - 1);

    logic [PHASE_W-1:0] phase;
    logic               keep_sample;

    // An accepted input that closes a group is the one forwarded downstream.
    always_comb begin
        keep_sample = in_valid && (phase == PHASE_LAST);
    end

    // Phase counter: counts accepted inputs modulo the decimation factor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (in_valid) begin
            if (phase == PHASE_LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Output data register: overwritten by each kept sample, never cleared
    // on consumption so the last value remains visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else if (keep_sample) begin
            out <= in;
        end
    end

    // Output valid flag: a new kept sample wins over a simultaneous consume,
    // and an unconsumed sample is silently replaced on overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
        end else if (keep_sample) begin
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_decimator
// Description : Self-checking bench for decimator (factor 5 and factor 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decimator;

    localparam int W = 12;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         vld = 1'b0;
    logic         rdy = 1'b0;

    logic [W-1:0] out5, out1;
    logic         ov5, ov1;

    int checks   = 0;
    int failures = 0;

    // Reference state: a count of accepted inputs since reset; a sample is
    // kept whenever that count reaches a multiple of the factor.
    int           acc5;
    logic [W-1:0] m5_out, m1_out;
    logic         m5_v, m1_v;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         ev;
        logic [W-1:0] eo;
    } vec_t;

    vec_t tbl[17];

    always #5 clk = ~clk;

    decimator #(.WORD_LENGTH_BITS(W), .DECIMATION_FACTOR(N)) dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(vld),
        .out(out5), .out_valid(ov5), .out_ready(rdy)
    );

    decimator #(.WORD_LENGTH_BITS(W), .DECIMATION_FACTOR(1)) dut1 (
        .clk(clk), .rst(rst), .in(din), .in_valid(vld),
        .out(out1), .out_valid(ov1), .out_ready(rdy)
    );

    task automatic chk(input string name, input logic [W-1:0] ao, input logic [W-1:0] eo,
                       input logic av, input logic ev);
        checks++;
        if (ao !== eo || av !== ev) begin
            failures++;
            $display("FAIL %s: out=%h out_valid=%b, expected out=%h out_valid=%b at %0t",
                     name, ao, av, eo, ev, $time);
        end
    endtask

    task automatic model_clear();
        acc5 = 0; m5_out = '0; m5_v = 1'b0; m1_out = '0; m1_v = 1'b0;
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (!v) model_clear();
    endtask

    // Advance the reference model by one edge using the current inputs.
    task automatic model_edge();
        if (!rst) begin
            model_clear();
        end else begin
            if (m5_v && rdy) m5_v = 1'b0;
            if (m1_v && rdy) m1_v = 1'b0;
            if (vld) begin
                acc5++;
                if (acc5 % N == 0) begin m5_out = din; m5_v = 1'b1; end
                m1_out = din; m1_v = 1'b1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        vld = v; din = d; rdy = r;
    endtask

    initial begin
        model_clear();
        tbl[0]  = '{1'b1, 12'd1,   1'b0, 1'b0, 12'd0};
        tbl[1]  = '{1'b1, 12'd2,   1'b0, 1'b0, 12'd0};
        tbl[2]  = '{1'b1, 12'd3,   1'b1, 1'b0, 12'd0};
        tbl[3]  = '{1'b1, 12'd4,   1'b0, 1'b0, 12'd0};
        tbl[4]  = '{1'b1, 12'd5,   1'b0, 1'b1, 12'd5};
        tbl[5]  = '{1'b0, 12'hAAA, 1'b0, 1'b1, 12'd5};
        tbl[6]  = '{1'b1, 12'd7,   1'b1, 1'b0, 12'd5};
        tbl[7]  = '{1'b0, 12'd0,   1'b1, 1'b0, 12'd5};
        tbl[8]  = '{1'b1, 12'd9,   1'b0, 1'b0, 12'd5};
        tbl[9]  = '{1'b1, 12'd10,  1'b0, 1'b0, 12'd5};
        tbl[10] = '{1'b1, 12'd11,  1'b0, 1'b0, 12'd5};
        tbl[11] = '{1'b1, 12'h800, 1'b0, 1'b1, 12'h800};
        tbl[12] = '{1'b1, 12'd13,  1'b0, 1'b1, 12'h800};
        tbl[13] = '{1'b1, 12'd14,  1'b1, 1'b0, 12'h800};
        tbl[14] = '{1'b1, 12'd15,  1'b1, 1'b0, 12'h800};
        tbl[15] = '{1'b1, 12'd16,  1'b1, 1'b0, 12'h800};
        tbl[16] = '{1'b1, 12'd17,  1'b1, 1'b1, 12'd17};

        // Reset hold with active inputs.
        drive(1'b1, 12'hAAA, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
            step();
            chk("reset_hold", out5, '0, ov5, 1'b0);
        end

        // Gating: no valid inputs means nothing changes.
        set_rst(1'b1);
        drive(1'b0, 12'hAAA, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("gating", out5, '0, ov5, 1'b0);
        end

        // Table-driven vectors.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            step();
            chk($sformatf("table[%0d]", i), out5, tbl[i].eo, ov5, tbl[i].ev);
        end

        // Asynchronous reset mid-group discards the partial count.
        drive(1'b1, 12'h123, 1'b1);
        repeat (3) step();
        #2 set_rst(1'b0);
        #1 chk("async_reset", out5, '0, ov5, 1'b0);
        drive(1'b0, 12'h0, 1'b0);
        step();
        set_rst(1'b1);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, W'(12'h100 + i), 1'b0);
            step();
            if (i < 5) chk("fresh_group", out5, '0, ov5, 1'b0);
            else       chk("fresh_group_last", out5, 12'h105, ov5, 1'b1);
        end

        // Consume, then overrun followed by simultaneous consume and new sample.
        drive(1'b0, 12'h0, 1'b1);
        step();
        chk("consume", out5, 12'h105, ov5, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            drive(1'b1, W'(i), (i == 15));
            step();
            if (i == 10) chk("overrun_10", out5, 12'd10, ov5, 1'b1);
            if (i == 15) chk("overrun_simul_15", out5, 12'd15, ov5, 1'b1);
        end
        drive(1'b0, 12'h0, 1'b1);
        step();
        chk("after_simul_consume", out5, 12'd15, ov5, 1'b0);

        // Handshake hold: valid held indefinitely while not ready.
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, W'(i + 200), 1'b0);
            step();
        end
        drive(1'b0, 12'h0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("hold_valid", out5, 12'd300, ov5, 1'b1);
        end
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("after_pulse", out5, 12'd300, ov5, 1'b0);
        end

        // Randomized traffic against the reference model, both factors.
        set_rst(1'b0);
        step();
        set_rst(1'b1);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 2) != 0), W'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 299) == 0) set_rst(1'b0);
            else if (!rst) set_rst(1'b1);
            step();
            chk("rand_f5", out5, m5_out, ov5, m5_v);
            chk("rand_f1", out1, m1_out, ov1, m1_v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decimator.md
Name: decimator

Overview:
- Integer downsampler. Keeps one of every DecimationFactor accepted input samples and drops the rest; no filtering is applied.
- Sits after a CIC integrator chain (or any sample stream) and feeds a valid/ready consumer.
- Output is a single-entry register with a valid/ready handshake. Input is valid-only and always accepted.

Parameters:
- WordLengthBits, default 12, width of the signed sample on in and out.
- DecimationFactor, default 5, number of accepted inputs per output sample. Must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in  input  WordLengthBits  signed input sample.
- in_valid  input  1  in carries a sample this cycle; always accepted, no backpressure.
- out  output  WordLengthBits  signed decimated sample, registered.
- out_valid  output  1  out holds an unconsumed sample.
- out_ready  input  1  consumer accepts out this cycle.

Behaviour:
- Reset: while rst=0, out=0, out_valid=0 and phase counter=0, immediately and independent of clk. This state is held for as long as rst is low, regardless of in, in_valid or out_ready.
- Phase counter width is max(1, $clog2(DecimationFactor)). It counts accepted inputs modulo DecimationFactor.
- On a rising edge with in_valid=1:
  - If counter==DecimationFactor-1: counter<=0, out<=in, out_valid<=1 (the group's last sample is kept).
  - Otherwise: counter<=counter+1, and out and out_valid are unchanged by the input.
- in_valid=0: counter, out and out_valid are unchanged by the input; in is ignored.
- Latency: out/out_valid update on the same edge that captures the Nth valid input. Example with factor 5: after 5 consecutive valid edges from reset, out_valid=1 after edge 5, with out equal to the sample presented at edge 5.
- Handshake:
  - An edge with out_valid=1 and out_ready=1 consumes the sample: out_valid<=0.
  - out_valid stays 1 indefinitely while out_ready=0.
  - out_ready has no effect when out_valid=0.
- out retains its last value after consumption; it is never cleared except by reset.
- Simultaneous consume and new decimated sample on one edge: out<=new sample, out_valid stays 1.
- Overrun (new decimated sample while out_valid=1 and out_ready=0): out is overwritten with the newest sample and out_valid stays 1. The older sample is dropped silently.
- DecimationFactor=1: every valid input is forwarded on its capture edge.
- Reset asserted mid-group discards any partial count; the next group starts fresh.
- No arithmetic is performed; the width is carried unchanged.

Decomposition:
- No shared package is required. Parameters are local to the module.
- Single flat module with no sub-modules. The phase counter is an inline always_ff block.
- The counter width constant is derived inside the module as a localparam.

Test Plan:
- Reset hold: rst=0 for 1000 cycles with in=12'hAAA, in_valid=1, out_ready=0 -> out=0 and out_valid=0 every cycle.
- Zero input: rst released, in=0, in_valid=1, out_ready=1 for 1000 cycles -> out=0 every cycle; out_valid pulses high after every 5th edge.
- Gating: in=12'hAAA, in_valid=0 for 1000 cycles -> out=0, out_valid=0. Then in=0, in_valid=1 -> out_valid=0 after edges 1-4 and 1 after edge 5, then 0 after edges 6-9 and 1 after edge 10. Then in_valid=0 -> out=0, out_valid=0 for 1000 cycles.
- Handshake hold: 100 valid inputs with out_ready=0 -> out_valid=1 held for 100 further idle cycles. Pulse out_ready for 1 cycle -> out_valid=0 for the next 100 cycles.
- Passthrough: in=12'hAAA constant, in_valid=1, out_ready=1 -> out=0 after edges 1-4, then 12'hAAA from edge 5 onward for 100 cycles.
- Sparse valids: 10 groups of five single-cycle in_valid pulses, each separated by 100 idle cycles, out_ready=1 -> out_valid=0 throughout, except 1 right after each 5th pulse.
- Overrun and simultaneous events: with out_ready=0, 10 valid inputs carrying values 1..10 -> out=10, out_valid=1. Then out_ready=1 on the edge that captures the 15th input (value 15) -> out=15, out_valid stays 1.
